div_128: RTL and testbench

DIV_128 -- requirements
Module: div_128

---
 rtl/div_128.sv | 116 +++++++++++
 tb/tb_div_128.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_128.sv
// 128/64 unsigned restoring divider with AXI-stream style handshakes.
// One quotient bit per cycle; fixed 128-cycle latency, divide-by-zero short-circuits to DONE.
module div_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] input_a_tdata,
  input  logic         input_a_tvalid,
  output logic         input_a_tready,
  input  logic [63:0]  input_b_tdata,
  input  logic         input_b_tvalid,
  output logic         input_b_tready,
  output logic [127:0] output_tdata,
  output logic [63:0]  output_rem,
  output logic         output_dbz,
  output logic         output_tvalid,
  input  logic         output_tready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [127:0] q;
  // The partial remainder is always below the divisor, so 64 bits hold it;
  // only the shifted trial value needs the extra bit.
  logic [63:0]  r;
  logic [63:0]  divisor;
  logic [6:0]   cnt;
  logic         dbz;

  logic         accept;
  logic         div_zero;
  logic [64:0]  trial;
  logic [63:0]  diff;
  logic         qbit;

  assign accept   = (state == IDLE) && input_a_tvalid && input_b_tvalid;
  assign div_zero = (input_b_tdata == 64'd0);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When the subtraction succeeds the true difference is below 2^64, so the
  // low 64 bits of the trial are enough to form it.
  always_comb begin
    trial = {r, q[127]};
    qbit  = (trial >= {1'b0, divisor});
    diff  = trial[63:0] - divisor;
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first, otherwise unassigned paths infer latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div_zero ? DONE : CALC;
      CALC: if (cnt == 7'd127) state_nxt = DONE;
      DONE: if (output_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q       <= '0;
      r       <= '0;
      divisor <= '0;
      cnt     <= '0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            divisor <= input_b_tdata;
            cnt     <= '0;
            if (div_zero) begin
              q   <= '1;
              r   <= input_a_tdata[63:0];
              dbz <= 1'b1;
            end else begin
              q   <= input_a_tdata;
              r   <= '0;
              dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          r   <= qbit ? diff : trial[63:0];
          q   <= {q[126:0], qbit};
          cnt <= cnt + 7'd1;
        end
        default: ;
      endcase
    end
  end

  // Ready is masked by reset so nothing can be accepted while rst is low.
  assign input_a_tready = (state == IDLE) && rst;
  assign input_b_tready = (state == IDLE) && rst;

  assign output_tvalid  = (state == DONE);
  assign output_tdata   = q;
  assign output_rem     = r;
  assign output_dbz     = dbz;

endmodule

// File: tb/tb_div_128.sv
// Directed self-checking bench for div_128: reset, arithmetic vectors,
// divide-by-zero, handshake/backpressure and reset in the middle of CALC.
module tb_div_128;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] input_a_tdata;
  logic         input_a_tvalid;
  logic         input_a_tready;
  logic [63:0]  input_b_tdata;
  logic         input_b_tvalid;
  logic         input_b_tready;
  logic [127:0] output_tdata;
  logic [63:0]  output_rem;
  logic         output_dbz;
  logic         output_tvalid;
  logic         output_tready;

  int tests = 0;
  int fails = 0;
  int lat;
  logic [127:0] prod;
  logic [127:0] held_q;
  logic [63:0]  held_r;

  always #5 clk = ~clk;

  div_128 dut (
    .clk            (clk),
    .rst            (rst),
    .input_a_tdata  (input_a_tdata),
    .input_a_tvalid (input_a_tvalid),
    .input_a_tready (input_a_tready),
    .input_b_tdata  (input_b_tdata),
    .input_b_tvalid (input_b_tvalid),
    .input_b_tready (input_b_tready),
    .output_tdata   (output_tdata),
    .output_rem     (output_rem),
    .output_dbz     (output_dbz),
    .output_tvalid  (output_tvalid),
    .output_tready  (output_tready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge while in IDLE. lat counts edges after the
  // acceptance edge until output_tvalid is seen (0 = valid right after it).
  task automatic run_op(input logic [127:0] a, input logic [63:0] b, output int n);
    input_a_tdata  = a;
    input_b_tdata  = b;
    input_a_tvalid = 1'b1;
    input_b_tvalid = 1'b1;
    @(posedge clk); #1;
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
    input_a_tdata  = ~a;
    input_b_tdata  = ~b;
    n = 0;
    while (!output_tvalid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume(input string tag);
    output_tready = 1'b1;
    @(posedge clk); #1;
    output_tready = 1'b0;
    check({tag, "_tvalid_drop"}, 128'(output_tvalid), 128'd0);
    check({tag, "_tready_back"}, 128'(input_a_tready & input_b_tready), 128'd1);
  endtask

  initial begin
    rst            = 1'b0;
    input_a_tdata  = '0;
    input_a_tvalid = 1'b0;
    input_b_tdata  = '0;
    input_b_tvalid = 1'b0;
    output_tready  = 1'b0;

    // Reset state, with valids offered to show nothing is taken during reset.
    repeat (3) @(posedge clk);
    #1;
    input_a_tvalid = 1'b1;
    input_b_tvalid = 1'b1;
    input_b_tdata  = 64'd3;
    check("rst_a_tready", 128'(input_a_tready), 128'd0);
    check("rst_b_tready", 128'(input_b_tready), 128'd0);
    check("rst_tvalid",   128'(output_tvalid), 128'd0);
    check("rst_tdata",    output_tdata, 128'd0);
    check("rst_rem",      128'(output_rem), 128'd0);
    check("rst_dbz",      128'(output_dbz), 128'd0);
    @(posedge clk); #1;
    check("rst_no_accept", 128'(output_tvalid), 128'd0);
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("post_rst_tready", 128'(input_a_tready & input_b_tready), 128'd1);
    @(posedge clk); #1;

    // Basic 100 / 7.
    run_op(128'd100, 64'd7, lat);
    check("basic_latency", 128'(lat), 128'd128);
    check("basic_q",   output_tdata, 128'd14);
    check("basic_rem", 128'(output_rem), 128'd2);
    check("basic_dbz", 128'(output_dbz), 128'd0);
    check("basic_tready_low", 128'(input_a_tready | input_b_tready), 128'd0);
    consume("basic");

    // Round trip on a full-width product.
    prod = 128'(64'd123123124443096802) * 128'(64'd314141255378583275);
    run_op(prod, 64'd314141255378583275, lat);
    check("rt_latency", 128'(lat), 128'd128);
    check("rt_q",   output_tdata, 128'd123123124443096802);
    check("rt_rem", 128'(output_rem), 128'd0);
    consume("rt");

    // Extremes.
    run_op({128{1'b1}}, 64'd1, lat);
    check("max_div1_q",   output_tdata, {128{1'b1}});
    check("max_div1_rem", 128'(output_rem), 128'd0);
    consume("max_div1");

    // output_tready held high throughout CALC must not disturb the op.
    output_tready = 1'b1;
    run_op(128'd5, 64'd9, lat);
    check("small_latency", 128'(lat), 128'd128);
    check("small_q",   output_tdata, 128'd0);
    check("small_rem", 128'(output_rem), 128'd5);
    output_tready = 1'b0;
    consume("small");

    // (2^128-1) = (2^64-1)(2^64+1); one less leaves remainder 2^64-2.
    run_op({128{1'b1}}, {64{1'b1}}, lat);
    check("maxmax_q",   output_tdata, {64'd1, 64'd1});
    check("maxmax_rem", 128'(output_rem), 128'd0);
    consume("maxmax");
    run_op({{127{1'b1}}, 1'b0}, {64{1'b1}}, lat);
    check("maxm1_q",   output_tdata, {64'd1, 64'd0});
    check("maxm1_rem", 128'(output_rem), 128'({{63{1'b1}}, 1'b0}));
    consume("maxm1");

    // Divide by zero: DONE directly from the acceptance edge.
    run_op(128'h1234, 64'd0, lat);
    check("dbz_latency", 128'(lat), 128'd0);
    check("dbz_q",   output_tdata, {128{1'b1}});
    check("dbz_rem", 128'(output_rem), 128'h1234);
    check("dbz_flag", 128'(output_dbz), 128'd1);
    consume("dbz");

    // One valid alone for 10 cycles: nothing accepted.
    input_a_tdata  = 128'd77;
    input_b_tdata  = 64'd5;
    input_a_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("a_only_tready", 128'(input_a_tready & input_b_tready), 128'd1);
      check("a_only_tvalid", 128'(output_tvalid), 128'd0);
    end
    input_a_tvalid = 1'b0;

    // Backpressure: results held for 20 cycles while inputs churn.
    run_op(128'd1000, 64'd33, lat);
    check("bp_q",   output_tdata, 128'd30);
    check("bp_rem", 128'(output_rem), 128'd10);
    held_q = output_tdata;
    held_r = output_rem;
    for (int i = 0; i < 20; i++) begin
      input_a_tvalid = 1'b1;
      input_b_tvalid = 1'b1;
      input_a_tdata  = 128'(i * 13 + 1);
      input_b_tdata  = 64'(i + 2);
      @(posedge clk); #1;
      check("bp_tvalid", 128'(output_tvalid), 128'd1);
      check("bp_hold_q", output_tdata, held_q);
      check("bp_hold_rem", 128'(output_rem), 128'(held_r));
      check("bp_tready", 128'(input_a_tready | input_b_tready), 128'd0);
    end
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
    consume("bp");

    // Reset in the middle of CALC.
    input_a_tdata  = 128'd1000000;
    input_b_tdata  = 64'd3;
    input_a_tvalid = 1'b1;
    input_b_tvalid = 1'b1;
    @(posedge clk); #1;
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_tvalid", 128'(output_tvalid), 128'd0);
    check("midrst_tdata",  output_tdata, 128'd0);
    check("midrst_rem",    128'(output_rem), 128'd0);
    check("midrst_dbz",    128'(output_dbz), 128'd0);
    check("midrst_tready", 128'(input_a_tready | input_b_tready), 128'd0);
    rst = 1'b1;
    #1;
    check("midrst_tready_back", 128'(input_a_tready & input_b_tready), 128'd1);
    @(posedge clk); #1;
    run_op(128'd100, 64'd7, lat);
    check("after_rst_latency", 128'(lat), 128'd128);
    check("after_rst_q",   output_tdata, 128'd14);
    check("after_rst_rem", 128'(output_rem), 128'd2);
    check("after_rst_dbz", 128'(output_dbz), 128'd0);
    consume("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
